// File: rtl/fp_add_normalize_if.sv
// Handshake and data bundle between the alignment stage, fp_add_normalize and its consumer.
// Drivers use the master view and the normalizer uses the slave view.
interface fp_add_normalize_if #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 11
);
  logic             in_valid;
  logic             in_ready;
  logic             sign_a;
  logic             sign_b;
  logic [MAN_W-1:0] man_a;
  logic [MAN_W-1:0] man_b;
  logic [EXP_W-1:0] exp_in;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      result;
  logic             ovf;
  logic             unf;

  modport master (
    output in_valid, sign_a, sign_b, man_a, man_b, exp_in, out_ready,
    input  in_ready, out_valid, result, ovf, unf
  );

  modport slave (
    input  in_valid, sign_a, sign_b, man_a, man_b, exp_in, out_ready,
    output in_ready, out_valid, result, ovf, unf
  );
endinterface

// File: rtl/fp_add_normalize.sv
// Back half of the binary16 adder: add/sub, LZC normalize, round/pack in a 3-stage pipeline.
// Define FP_NORM_ROUND_EN for round-half-to-even on the carry path (truncation otherwise).
module fp_add_normalize #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 11
) (
  input logic                clk,
  input logic                rst,
  fp_add_normalize_if.slave  bus_io
);

  logic adv;
  assign adv             = !(bus_io.out_valid && !bus_io.out_ready);
  assign bus_io.in_ready = adv;

  // Stage 1: signed-magnitude add/subtract
  logic             s1_valid_q;
  logic             s1_sign_q, s1_sign_d;
  logic [MAN_W:0]   s1_sum_q, s1_sum_d;
  logic [EXP_W-1:0] s1_exp_q;

  always_comb begin
    if (bus_io.sign_a == bus_io.sign_b) begin
      s1_sum_d  = {1'b0, bus_io.man_a} + {1'b0, bus_io.man_b};
      s1_sign_d = bus_io.sign_a;
    end else if (bus_io.man_a >= bus_io.man_b) begin
      s1_sum_d  = {1'b0, bus_io.man_a - bus_io.man_b};
      s1_sign_d = (bus_io.man_a == bus_io.man_b) ? 1'b0 : bus_io.sign_a;
    end else begin
      s1_sum_d  = {1'b0, bus_io.man_b - bus_io.man_a};
      s1_sign_d = bus_io.sign_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sum_q   <= '0;
      s1_exp_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= bus_io.in_valid;
      s1_sign_q  <= s1_sign_d;
      s1_sum_q   <= s1_sum_d;
      s1_exp_q   <= bus_io.exp_in;
    end
  end

  // Stage 2: normalize
  logic [3:0]        lz;
  logic signed [6:0] s1_exp_ext;
  logic              s2_valid_q;
  logic              s2_sign_q;
  logic [MAN_W-1:0]  s2_man_q, s2_man_d;
  logic signed [6:0] s2_exp_q, s2_exp_d;
  logic              s2_zero_q, s2_zero_d;
  logic              s2_unf_q, s2_unf_d;
`ifdef FP_NORM_ROUND_EN
  logic              s2_guard_q, s2_guard_d;
`endif

  assign s1_exp_ext = signed'({2'b00, s1_exp_q});

  // Highest set bit wins because the loop scans upward.
  always_comb begin
    lz = 4'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (s1_sum_q[i]) lz = 4'(MAN_W - 1 - i);
    end
  end

  always_comb begin
    s2_man_d   = '0;
    s2_exp_d   = s1_exp_ext;
    s2_zero_d  = 1'b0;
    s2_unf_d   = 1'b0;
`ifdef FP_NORM_ROUND_EN
    s2_guard_d = 1'b0;
`endif
    if (s1_sum_q[MAN_W]) begin
      s2_man_d   = s1_sum_q[MAN_W:1];
      s2_exp_d   = s1_exp_ext + 7'sd1;
`ifdef FP_NORM_ROUND_EN
      s2_guard_d = s1_sum_q[0];
`endif
    end else if (s1_sum_q == '0) begin
      s2_zero_d = 1'b1;
    end else if (s1_exp_q <= {1'b0, lz}) begin
      // Would need a denormal; flush to +0 instead.
      s2_zero_d = 1'b1;
      s2_unf_d  = 1'b1;
    end else begin
      s2_man_d = s1_sum_q[MAN_W-1:0] << lz;
      s2_exp_d = s1_exp_ext - signed'({3'b000, lz});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_man_q   <= '0;
      s2_exp_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_unf_q   <= 1'b0;
`ifdef FP_NORM_ROUND_EN
      s2_guard_q <= 1'b0;
`endif
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_man_q   <= s2_man_d;
      s2_exp_q   <= s2_exp_d;
      s2_zero_q  <= s2_zero_d;
      s2_unf_q   <= s2_unf_d;
`ifdef FP_NORM_ROUND_EN
      s2_guard_q <= s2_guard_d;
`endif
    end
  end

  // Stage 3: round and pack
  logic [MAN_W:0]    rnd_man;
  logic signed [6:0] rnd_exp;
  logic [15:0]       res_d;
  logic              ovf_d, unf_d;
  logic              unused_hidden;

  always_comb begin
    rnd_man = {1'b0, s2_man_q};
    rnd_exp = s2_exp_q;
`ifdef FP_NORM_ROUND_EN
    // Single dropped bit: a set guard is an exact tie, so round up only on an odd LSB.
    rnd_man = rnd_man + {{MAN_W{1'b0}}, s2_guard_q & s2_man_q[0]};
    if (rnd_man[MAN_W]) begin
      rnd_man = rnd_man >> 1;
      rnd_exp = rnd_exp + 7'sd1;
    end
`endif
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s2_zero_q) begin
      unf_d = s2_unf_q;
    end else if (rnd_exp >= 7'sd31) begin
      res_d = {s2_sign_q, 5'h1F, 10'h000};
      ovf_d = 1'b1;
    end else begin
      res_d = {s2_sign_q, rnd_exp[4:0], rnd_man[9:0]};
    end
  end

  assign unused_hidden = rnd_man[MAN_W] ^ rnd_man[MAN_W-1];

  logic        out_valid_q;
  logic [15:0] result_q;
  logic        ovf_q, unf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      result_q    <= s2_valid_q ? res_d : 16'h0000;
      ovf_q       <= s2_valid_q & ovf_d;
      unf_q       <= s2_valid_q & unf_d;
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.result    = result_q;
  assign bus_io.ovf       = ovf_q;
  assign bus_io.unf       = unf_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Self-checking bench for fp_add_normalize: directed table, backpressure/reset sequences and
// randomized traffic scored against an arithmetic reference model.
module tb_fp_add_normalize;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fp_add_normalize_if #(.EXP_W(5), .MAN_W(11)) bus();

  fp_add_normalize #(.EXP_W(5), .MAN_W(11)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

`ifdef FP_NORM_ROUND_EN
  localparam logic [15:0] RndRes = 16'h4002;
`else
  localparam logic [15:0] RndRes = 16'h4001;
`endif

  typedef struct {
    bit          sa;
    bit          sb;
    logic [10:0] ma;
    logic [10:0] mb;
    logic [4:0]  e;
    logic [15:0] res;
    bit          ovf;
    bit          unf;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          n_out  = 0;
  logic [17:0] expq[$];
  vec_t        vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Computes the value from magnitudes and the MSB position, not from the pipeline structure.
  function automatic logic [17:0] ref_model(bit sa, bit sb, int ma, int mb, int e);
    int mag, p, ex, mant;
    bit s;
    if (sa == sb) begin
      mag = ma + mb; s = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; s = sa;
    end else begin
      mag = mb - ma; s = sb;
    end
    if (mag == 0) return 18'h0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    ex = e + p - 10;
    if (p == 11) begin
      mant = mag >> 1;
`ifdef FP_NORM_ROUND_EN
      if ((mag % 2 == 1) && (mant % 2 == 1)) mant++;
      if (mant == 2048) begin
        mant = mant >> 1;
        ex++;
      end
`endif
    end else begin
      if (ex <= 0) return {16'h0000, 2'b01};
      mant = mag << (10 - p);
    end
    if (ex >= 31) return {s, 5'h1F, 10'h000, 2'b10};
    return {s, ex[4:0], mant[9:0], 2'b00};
  endfunction

  task automatic set_vec(input vec_t v);
    bus.sign_a = v.sa;
    bus.sign_b = v.sb;
    bus.man_a  = v.ma;
    bus.man_b  = v.mb;
    bus.exp_in = v.e;
  endtask

  task automatic set_rand();
    bus.sign_a = 1'($urandom);
    bus.sign_b = 1'($urandom);
    bus.man_a  = 11'($urandom_range(0, 2047));
    bus.man_b  = 11'($urandom_range(0, 2047));
    bus.exp_in = 5'($urandom_range(1, 31));
  endtask

  // Called at a negedge with inputs set; scores one cycle and advances to the next negedge.
  task automatic tick(output bit acc);
    logic [17:0] e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: got result %h expected no output", bus.result);
      end else begin
        e = expq.pop_front();
        chk("stream_result", {14'b0, bus.result, bus.ovf, bus.unf}, {14'b0, e});
      end
    end else if (!bus.out_valid) begin
      chk("idle_flags", {30'b0, bus.ovf, bus.unf}, 32'h0);
    end
    if (acc) expq.push_back(ref_model(bus.sign_a, bus.sign_b, int'(bus.man_a),
                                      int'(bus.man_b), int'(bus.exp_in)));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
  endtask

  initial begin
    bit acc;
    int lat;
    int base;
    int k;
    int stall_left;
    bit seen;
    logic [15:0] held;
    int bp[4];

    vecs[0]  = '{0, 0, 11'h400, 11'h400, 5'd15, 16'h4000, 0, 0};
    vecs[1]  = '{0, 1, 11'h600, 11'h400, 5'd15, 16'h3800, 0, 0};
    vecs[2]  = '{0, 1, 11'h555, 11'h555, 5'd20, 16'h0000, 0, 0};
    vecs[3]  = '{0, 0, 11'h7FF, 11'h7FF, 5'd30, 16'h7C00, 1, 0};
    vecs[4]  = '{0, 1, 11'h401, 11'h400, 5'd5,  16'h0000, 0, 1};
    vecs[5]  = '{0, 0, 11'h403, 11'h400, 5'd15, RndRes,   0, 0};
    vecs[6]  = '{0, 1, 11'h400, 11'h600, 5'd15, 16'hB800, 0, 0};
    vecs[7]  = '{1, 1, 11'h400, 11'h400, 5'd15, 16'hC000, 0, 0};
    vecs[8]  = '{0, 0, 11'h500, 11'h000, 5'd31, 16'h7C00, 1, 0};
    vecs[9]  = '{1, 0, 11'h7FF, 11'h7FF, 5'd10, 16'h0000, 0, 0};
    vecs[10] = '{0, 1, 11'h401, 11'h400, 5'd11, 16'h0400, 0, 0};
    vecs[11] = '{0, 1, 11'h401, 11'h400, 5'd10, 16'h0000, 0, 1};
    bp = '{0, 1, 6, 7};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_vec(vecs[0]);
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_result",    {16'b0, bus.result},    32'h0);
    chk("rst_flags",     {30'b0, bus.ovf, bus.unf}, 32'h0);
    chk("rst_in_ready",  {31'b0, bus.in_ready},  32'h1);

    // Directed table, one op at a time, checking latency too
    foreach (vecs[i]) begin
      set_vec(vecs[i]);
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_result", i), {16'b0, bus.result}, {16'b0, vecs[i].res});
      chk($sformatf("vec%0d_flags", i), {30'b0, bus.ovf, bus.unf},
          {30'b0, vecs[i].ovf, vecs[i].unf});
      @(posedge clk);
      @(negedge clk);
    end

    // Backpressure: 4 ops, 5-cycle stall once the first result shows
    do_reset();
    base = n_out;
    k = 0;
    seen = 1'b0;
    stall_left = 0;
    held = '0;
    for (int cyc = 0; cyc < 40 && !(k == 4 && expq.size() == 0 && seen); cyc++) begin
      bus.in_valid = (k < 4);
      if (k < 4) set_vec(vecs[bp[k]]);
      if (bus.out_valid && !seen) begin
        seen = 1'b1;
        stall_left = 5;
        held = bus.result;
      end
      bus.out_ready = (stall_left == 0);
      if (stall_left > 0) begin
        #1;
        chk("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
        chk("stall_hold", {16'b0, bus.result}, {16'b0, held});
        stall_left--;
      end
      tick(acc);
      if (acc) k++;
    end
    bus.in_valid = 1'b0;
    chk("bp_count", n_out - base, 4);
    chk("bp_drained", expq.size(), 0);

    // Reset mid-stream discards in-flight work
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      set_rand();
      tick(acc);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    for (int c = 0; c < 4; c++) begin
      chk("rst_flush", {31'b0, bus.out_valid}, 32'h0);
      @(posedge clk);
      @(negedge clk);
    end

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      set_rand();
      tick(acc);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && expq.size() > 0; c++) tick(acc);
    chk("drain", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
